text_renderer: RTL and testbench
================================

TEXT_RENDERER -- requirements
Module: text_renderer

Interface
REQ-001 Parameter COLS, default 16, characters per text line.
REQ-002 Parameter ROWS, default 4, text lines.
REQ-003 Parameter SCALE_LOG2, default 0, glyph magnification 2^SCALE_LOG2 (0..3).
REQ-004 Parameters ORIGIN_X / ORIGIN_Y, default 0 / 0, top-left pixel of the text area.
REQ-005 Parameters X_W / Y_W, default 10 / 10, coordinate widths.
REQ-006 Parameter BLINK_CYCLES, default 25_000_000, clocks per cursor blink half-period (>=2).
REQ-007 Derived ADDR_W = clog2(COLS*ROWS); CELLS = COLS*ROWS.
REQ-008 clk  in  1  single clock, all logic on rising edge.
REQ-009 rst  in  1  reset, synchronous, active-high.
REQ-010 pixel_valid  in  1  pixel_x/pixel_y qualify this cycle.
REQ-011 pixel_x  in  X_W  raster column; pixel_y  in  Y_W  raster row.
REQ-012 wr_en  in  1  character-buffer write strobe.
REQ-013 wr_addr  in  ADDR_W  cell index (row*COLS+col); wr_char  in  8  ASCII code.
REQ-014 cursor_en  in  1  cursor enable; cursor_addr  in  ADDR_W  cursor cell.
REQ-015 pix_valid  out  1  pix_on qualified; pix_on  out  1  foreground pixel.
REQ-016 busy  out  1  buffer clear in progress.

Function
REQ-017 Cell size SHALL be 8x8 glyph pixels times 2^SCALE_LOG2 in each axis; cell col = (pixel_x-ORIGIN_X)>>(3+SCALE_LOG2), glyph bit = ((pixel_x-ORIGIN_X)>>SCALE_LOG2)&7, same for rows.
REQ-018 Pixel outside [ORIGIN, ORIGIN+COLS*8*scale) x [ORIGIN_Y, ORIGIN_Y+ROWS*8*scale) SHALL give pix_on=0 (no wrap, no cursor).
REQ-019 Pipeline SHALL be 3 stages: S1 register coords/compute cell, in-area, bit; S2 synchronous buffer read; S3 glyph lookup, bit select, cursor overlay.
REQ-020 pix_valid SHALL equal pixel_valid delayed exactly 3 clocks; pix_on SHALL be 0 whenever pix_valid=0.
REQ-021 Glyph row bit 7 SHALL be leftmost pixel; glyph rows 6-7 blank; glyph set: space, A C E G M N O P R T U; all other codes blank.
REQ-022 Write SHALL update buffer at clock edge; read of same cell in same cycle SHALL return old value.
REQ-023 wr_addr >= CELLS SHALL be ignored; cursor_addr >= CELLS SHALL show no cursor.
REQ-024 Blink counter SHALL count 0..BLINK_CYCLES-1 and toggle blink_phase on wrap, free-running regardless of cursor_en.
REQ-025 When cursor_en=1, blink_phase=1 and in-area pixel cell == cursor_addr, pix_on SHALL be inverted glyph bit.
REQ-026 Clear FSM states: CLEAR (write 0x20 to cell clr_idx, increment each clock) -> RUN after cell CELLS-1; RUN holds until rst.
REQ-027 In CLEAR: busy=1, wr_en ignored, pix_on forced 0 (pix_valid still tracks pixel_valid); CLEAR lasts exactly CELLS clocks after rst deasserts.

Reset
REQ-028 rst=1 SHALL set: state CLEAR, clr_idx 0, blink counter 0, blink_phase 0, all pipeline valid bits 0, pix_valid 0, pix_on 0, busy 1.
REQ-029 rst asserted mid-clear or mid-run SHALL restart full clear; in-flight pixels discarded.

Structure
REQ-030 Shared package text_pkg SHALL hold glyph constants (GLYPH_W=8, GLYPH_H=8, SPACE_CODE=8'h20) and FSM state encoding.
REQ-031 Glyph table SHALL be sub-module glyph_rom (char_code 8, row 3 -> bits 8, combinational); character buffer inferred inside text_renderer.

Verification
REQ-032 Reset, release -> busy=1 for 64 clocks (COLS=16,ROWS=4), then 0; scan all pixels -> pix_on all 0.
REQ-033 Write 'P' to cell 0, drive (0,0) valid -> 3 clocks later pix_valid=1, pix_on=1; (4,0) -> 0; (4,1) -> 1.
REQ-034 SCALE_LOG2=1, 'T' at cell 1: (16..25,0) -> 1, (26,0) -> 0; (32,0) -> column of cell 2.
REQ-035 Write 'E' to cell 5 and read cell 5 same cycle -> old space (0); next read -> 'E' pattern.
REQ-036 BLINK_CYCLES=4, cursor_en=1, cursor_addr=0, cell 0 space: pixel (0,0) repeatedly -> pix_on 0 for 4 clocks, 1 for 4, alternating.
REQ-037 wr_addr=64 write, wr_en during CLEAR, rst mid-clear -> buffer unchanged, clear restarts, busy 64 more clocks.

Source files
------------

// File: rtl/text_pkg.sv
// Shared constants for the text renderer: glyph geometry, the blank code
// written during buffer clear, and the clear/run FSM encoding.
package text_pkg;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 8;
  localparam logic [7:0] SPACE_CODE = 8'h20;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  typedef logic [7:0] glyph_row_t;

endpackage

// File: rtl/glyph_rom.sv
// Combinational 8x8 glyph table; bit 7 is the leftmost pixel, rows 6-7 blank.
// Only space and A C E G M N O P R T U are drawn; every other code is blank.
module glyph_rom
  import text_pkg::*;
(
  input  logic [7:0]  char_code,
  input  logic [2:0]  row,
  output glyph_row_t  bits
);

  // rows 0..5 packed top row first
  logic [47:0] pat;

  always_comb begin
    pat = 48'h0;
    case (char_code)
      SPACE_CODE: pat = 48'h00_00_00_00_00_00;
      8'h41:      pat = 48'h70_88_88_F8_88_88;
      8'h43:      pat = 48'h78_80_80_80_80_78;
      8'h45:      pat = 48'hF8_80_F0_80_80_F8;
      8'h47:      pat = 48'h78_80_B8_88_88_78;
      8'h4D:      pat = 48'h88_D8_A8_88_88_88;
      8'h4E:      pat = 48'h88_C8_A8_98_88_88;
      8'h4F:      pat = 48'h70_88_88_88_88_70;
      8'h50:      pat = 48'hF0_88_88_F0_80_80;
      8'h52:      pat = 48'hF0_88_F0_A0_90_88;
      8'h54:      pat = 48'hF8_20_20_20_20_20;
      8'h55:      pat = 48'h88_88_88_88_88_70;
      default:    pat = 48'h0;
    endcase
  end

  always_comb begin
    bits = 8'h00;
    case (row)
      3'd0:    bits = pat[47:40];
      3'd1:    bits = pat[39:32];
      3'd2:    bits = pat[31:24];
      3'd3:    bits = pat[23:16];
      3'd4:    bits = pat[15:8];
      3'd5:    bits = pat[7:0];
      default: bits = 8'h00;
    endcase
  end

endmodule

// File: rtl/text_renderer.sv
// Character-cell text overlay: 3-stage pixel pipeline over an inferred
// character buffer, blinking inverse cursor, and a clear-on-reset sequencer.
//
//   state    | meaning
//   ST_CLEAR | writing SPACE_CODE to every cell, host writes ignored, pixels off
//   ST_RUN   | normal rendering, host writes accepted
module text_renderer
  import text_pkg::*;
#(
  parameter int COLS         = 16,
  parameter int ROWS         = 4,
  parameter int SCALE_LOG2   = 0,
  parameter int ORIGIN_X     = 0,
  parameter int ORIGIN_Y     = 0,
  parameter int X_W          = 10,
  parameter int Y_W          = 10,
  parameter int BLINK_CYCLES = 25_000_000,
  localparam int CELLS       = COLS * ROWS,
  localparam int ADDR_W      = $clog2(CELLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pixel_valid,
  input  logic [X_W-1:0]    pixel_x,
  input  logic [Y_W-1:0]    pixel_y,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_char,
  input  logic              cursor_en,
  input  logic [ADDR_W-1:0] cursor_addr,
  output logic              pix_valid,
  output logic              pix_on,
  output logic              busy
);

  localparam int SHIFT  = 3 + SCALE_LOG2;
  localparam int AREA_W = COLS * GLYPH_W * (1 << SCALE_LOG2);
  localparam int AREA_H = ROWS * GLYPH_H * (1 << SCALE_LOG2);
  localparam int BC_W   = $clog2(BLINK_CYCLES);

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_idx;
  logic [BC_W-1:0]   blink_cnt;
  logic              blink_phase;

  logic [7:0]        buffer [CELLS];
  logic              buf_we;
  logic [ADDR_W-1:0] buf_wa;
  logic [7:0]        buf_wd;

  logic [31:0]       dx, dy;
  logic              in_area;
  logic [ADDR_W-1:0] col_c, row_c, cell_c;

  logic              v1, in1, v2, in2;
  logic [ADDR_W-1:0] cell1, cell2;
  logic [2:0]        bx1, by1, bx2, by2;
  logic [7:0]        ch2;
  glyph_row_t        gbits;
  logic              gbit, cursor_hit;

  assign busy = (state == ST_CLEAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_idx <= '0;
    end else if (state == ST_CLEAR) begin
      if (32'(clr_idx) == 32'(CELLS - 1)) state <= ST_RUN;
      else                                clr_idx <= clr_idx + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (32'(blink_cnt) == 32'(BLINK_CYCLES - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + BC_W'(1);
    end
  end

  // Clear owns the write port; out-of-range host addresses are dropped.
  always_comb begin
    buf_we = 1'b0;
    buf_wa = wr_addr;
    buf_wd = wr_char;
    if (state == ST_CLEAR) begin
      buf_we = 1'b1;
      buf_wa = clr_idx;
      buf_wd = SPACE_CODE;
    end else if (wr_en && (32'(wr_addr) < 32'(CELLS))) begin
      buf_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) buffer[buf_wa] <= buf_wd;
  end

  // Pixels left of/above the origin wrap to huge offsets and fail the bound.
  always_comb begin
    dx      = 32'(pixel_x) - 32'(ORIGIN_X);
    dy      = 32'(pixel_y) - 32'(ORIGIN_Y);
    in_area = (dx < 32'(AREA_W)) && (dy < 32'(AREA_H));
    col_c   = dx[SHIFT +: ADDR_W];
    row_c   = dy[SHIFT +: ADDR_W];
    cell_c  = in_area ? ADDR_W'(row_c * ADDR_W'(COLS) + col_c) : '0;
  end

  glyph_rom u_glyph_rom (
    .char_code (ch2),
    .row       (by2),
    .bits      (gbits)
  );

  assign gbit       = gbits[3'd7 - bx2];
  assign cursor_hit = cursor_en && blink_phase &&
                      (32'(cursor_addr) < 32'(CELLS)) && (cell2 == cursor_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      pix_valid <= 1'b0;
      pix_on    <= 1'b0;
    end else begin
      v1        <= pixel_valid;
      v2        <= v1;
      pix_valid <= v2;
      pix_on    <= v2 && in2 && (state == ST_RUN) && (gbit ^ cursor_hit);
    end
    in1   <= in_area;
    cell1 <= cell_c;
    bx1   <= dx[SCALE_LOG2 +: 3];
    by1   <= dy[SCALE_LOG2 +: 3];
    in2   <= in1;
    cell2 <= cell1;
    bx2   <= bx1;
    by2   <= by1;
    ch2   <= buffer[cell1];
  end

endmodule

// File: tb/tb_text_renderer.sv
// Scoreboard bench: u0 is the default 16x4 layout, u1 is 16x3 at 2x scale.
module tb_text_renderer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pv0 = 1'b0, pv1 = 1'b0;
  logic [9:0] px = '0, py = '0;
  logic       wr_en = 1'b0;
  logic [5:0] wr_addr = '0;
  logic [7:0] wr_char = '0;
  logic       cen0 = 1'b0, cen1 = 1'b0;
  logic [5:0] caddr0 = '0, caddr1 = '0;
  logic       pix_valid0, pix_on0, busy0;
  logic       pix_valid1, pix_on1, busy1;

  int checks = 0, errors = 0;
  int cyc = 0, relcnt = 0;

  bit    q0[$], q1[$];
  string n0[$], n1[$];
  int    t0[$], t1[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    relcnt <= rst ? 0 : relcnt + 1;
  end

  text_renderer #(.BLINK_CYCLES(4)) u0 (
    .clk(clk), .rst(rst), .pixel_valid(pv0), .pixel_x(px), .pixel_y(py),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
    .cursor_en(cen0), .cursor_addr(caddr0),
    .pix_valid(pix_valid0), .pix_on(pix_on0), .busy(busy0)
  );

  text_renderer #(.ROWS(3), .SCALE_LOG2(1), .BLINK_CYCLES(4)) u1 (
    .clk(clk), .rst(rst), .pixel_valid(pv1), .pixel_x(px), .pixel_y(py),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
    .cursor_en(cen1), .cursor_addr(caddr1),
    .pix_valid(pix_valid1), .pix_on(pix_on1), .busy(busy1)
  );

  string mn0, mn1;
  bit    me0, me1;
  int    mt0, mt1;

  always @(negedge clk) begin
    if (pix_valid0) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pix0: pix_on=%0d with nothing pending", pix_on0);
      end else begin
        me0 = q0.pop_front(); mn0 = n0.pop_front(); mt0 = t0.pop_front();
        if (pix_on0 !== me0 || cyc - mt0 != 3) begin
          errors++;
          $display("FAIL u0 %s: pix_on=%0d latency=%0d, expected pix_on=%0d latency=3",
                   mn0, pix_on0, cyc - mt0, me0);
        end
      end
    end else if (pix_on0 !== 1'b0) begin
      checks++; errors++;
      $display("FAIL u0 pix_on_unqualified: pix_on=%0d while pix_valid=0", pix_on0);
    end
  end

  always @(negedge clk) begin
    if (pix_valid1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pix1: pix_on=%0d with nothing pending", pix_on1);
      end else begin
        me1 = q1.pop_front(); mn1 = n1.pop_front(); mt1 = t1.pop_front();
        if (pix_on1 !== me1 || cyc - mt1 != 3) begin
          errors++;
          $display("FAIL u1 %s: pix_on=%0d latency=%0d, expected pix_on=%0d latency=3",
                   mn1, pix_on1, cyc - mt1, me1);
        end
      end
    end else if (pix_on1 !== 1'b0) begin
      checks++; errors++;
      $display("FAIL u1 pix_on_unqualified: pix_on=%0d while pix_valid=0", pix_on1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic issue(input bit e0, input bit x0, input bit e1, input bit x1,
                       input int x, input int y, input bit keep, input string nm);
    px  = 10'(x);
    py  = 10'(y);
    pv0 = e0;
    pv1 = e1;
    if (keep && e0) begin q0.push_back(x0); n0.push_back(nm); t0.push_back(cyc); end
    if (keep && e1) begin q1.push_back(x1); n1.push_back(nm); t1.push_back(cyc); end
    step();
    pv0 = 1'b0;
    pv1 = 1'b0;
  endtask

  task automatic wr(input int addr, input logic [7:0] ch);
    wr_en   = 1'b1;
    wr_addr = 6'(addr);
    wr_char = ch;
    step();
    wr_en   = 1'b0;
  endtask

  int n0c, n1c;

  initial begin
    repeat (3) step();
    chk("reset_busy0", 32'(busy0), 1);
    chk("reset_busy1", 32'(busy1), 1);
    chk("reset_pix_valid0", 32'(pix_valid0), 0);
    chk("reset_pix_on0", 32'(pix_on0), 0);

    // first clear: pixels still flow but stay dark; the last two are in
    // flight when rst returns and must vanish
    rst = 1'b0;
    for (int i = 1; i <= 20; i++) issue(1, 0, 1, 0, 0, 0, i <= 18, "clear_dark");
    chk("busy_mid_clear0", 32'(busy0), 1);
    rst = 1'b1;
    step(); step();
    rst = 1'b0;

    n0c = -1; n1c = -1;
    for (int i = 1; i <= 200 && (n0c < 0 || n1c < 0); i++) begin
      if (i == 10) begin wr_en = 1'b1; wr_addr = 6'd3; wr_char = 8'h41; end
      step();
      wr_en = 1'b0;
      if (!busy0 && n0c < 0) n0c = i;
      if (!busy1 && n1c < 0) n1c = i;
    end
    chk("clear_len0", 32'(n0c), 64);
    chk("clear_len1", 32'(n1c), 48);

    for (int y = 0; y < 34; y++)
      for (int x = 0; x < 136; x++) issue(1, 0, 1, 0, x, y, 1, "scan_blank");

    wr(0, 8'h50);
    wr(1, 8'h54);
    wr(2, 8'h55);
    wr(16, 8'h50);

    issue(1, 1, 0, 0,   0,  0, 1, "P_0_0");
    issue(1, 0, 0, 0,   4,  0, 1, "P_4_0");
    issue(1, 1, 0, 0,   4,  1, 1, "P_4_1");
    issue(1, 1, 0, 0,   8,  0, 1, "T_8_0");
    issue(1, 1, 0, 0,  12,  0, 1, "T_12_0");
    issue(1, 0, 0, 0,  13,  0, 1, "T_13_0");
    issue(1, 1, 0, 0,   0,  8, 1, "P_cell16");
    issue(1, 0, 0, 0, 128,  0, 1, "right_edge_no_wrap");
    issue(1, 0, 0, 0,   0, 32, 1, "bottom_edge_no_wrap");
    issue(1, 0, 0, 0,  24,  1, 1, "clear_ignores_wr");

    for (int x = 16; x <= 25; x++) issue(0, 0, 1, 1, x, 0, 1, "x2_T_on");
    issue(0, 0, 1, 0,  26,  0, 1, "x2_T_26_off");
    issue(0, 0, 1, 1,  32,  0, 1, "x2_cell2_U");
    issue(0, 0, 1, 0,  34,  0, 1, "x2_U_34_off");
    issue(0, 0, 1, 0,  16,  2, 1, "x2_T_row1_left");
    issue(0, 0, 1, 1,  20,  2, 1, "x2_T_row1_stem");
    issue(0, 0, 1, 1,   0, 16, 1, "x2_P_cell16");
    issue(0, 0, 1, 0, 256,  0, 1, "x2_right_edge");

    // read of cell 5 reaches the buffer on the same edge as the write
    issue(1, 0, 0, 0, 40, 0, 1, "E_same_edge_old");
    wr(5, 8'h45);
    issue(1, 1, 0, 0, 40, 0, 1, "E_after_write");

    // blink phase after edge k since release is (k/4)%2; the overlay for a
    // pixel sampled at edge n uses the phase after edge n+1
    wr(0, 8'h20);
    cen0 = 1'b1;
    caddr0 = 6'd0;
    for (int i = 0; i < 24; i++)
      issue(1, bit'(((relcnt + 2) / 4) % 2), 0, 0, 0, 0, 1, "cursor_blink");
    issue(1, 1, 0, 0, 8,  0, 1, "cursor_other_cell");
    issue(1, 0, 0, 0, 0, 32, 1, "cursor_out_of_area");
    cen0 = 1'b0;
    for (int i = 0; i < 4; i++) issue(1, 0, 0, 0, 0, 0, 1, "cursor_disabled");

    for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) step();
    chk("drain_q0", 32'(q0.size()), 0);
    chk("drain_q1", 32'(q1.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
